// File: rtl/traffic_pkg.sv
// Constants shared by the traffic-light FSM, the phase timer and the display driver.
package traffic_pkg;

   localparam int unsigned TIMER_W         = 8;
   localparam int unsigned WARN_THRESH_DEF = 3;
   localparam int unsigned BCD_W           = 4;
   localparam int unsigned BCD_DIGITS      = 3;

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational double-dabble: binary value to three BCD digits.
module bin_to_bcd
   import traffic_pkg::*;
#(
   parameter int unsigned IN_W = TIMER_W
) (
   input  logic [IN_W-1:0]  bin,
   output logic [BCD_W-1:0] hundreds,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones
);

   localparam int unsigned SCR_W = BCD_DIGITS * BCD_W;

   logic [SCR_W-1:0] scratch;

   // Before each shift, any digit >= 5 gets +3 so it carries correctly into the next digit.
   always_comb begin
      scratch = '0;
      for (int i = int'(IN_W) - 1; i >= 0; i--) begin
         for (int d = 0; d < int'(BCD_DIGITS); d++) begin
            if (scratch[d*BCD_W +: BCD_W] >= 4'd5) begin
               scratch[d*BCD_W +: BCD_W] = scratch[d*BCD_W +: BCD_W] + 4'd3;
            end
         end
         scratch = {scratch[SCR_W-2:0], bin[i]};
      end
   end

   assign ones     = scratch[0*BCD_W +: BCD_W];
   assign tens     = scratch[1*BCD_W +: BCD_W];
   assign hundreds = scratch[2*BCD_W +: BCD_W];

endmodule

// File: rtl/countdown_timer.sv
// Phase-duration countdown for the traffic-light FSM: load/hold/decrement with
// a one-cycle time_up pulse, end-of-phase warning and BCD display digits.
module countdown_timer
   import traffic_pkg::*;
#(
   parameter int unsigned WIDTH       = TIMER_W,
   parameter int unsigned WARN_THRESH = WARN_THRESH_DEF
) (
   input  logic             clk_1hz,
   input  logic             reset_n,
   input  logic             load_timer,
   input  logic [WIDTH-1:0] timer_preset,
   input  logic             hold,
   output logic             time_up,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             warn,
   output logic [BCD_W-1:0] bcd_hundreds,
   output logic [BCD_W-1:0] bcd_tens,
   output logic [BCD_W-1:0] bcd_ones
);

   logic [WIDTH-1:0] count_d, count_q;
   logic             running_d, running_q;

   // Priority load > hold > decrement; a zero preset becomes 1 so a phase always ends.
   always_comb begin
      count_d = count_q;
      if (load_timer) begin
         count_d = (timer_preset == '0) ? WIDTH'(1) : timer_preset;
      end else if (!hold && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
      running_d = (count_d != '0);
   end

   always_ff @(posedge clk_1hz or negedge reset_n) begin
      if (!reset_n) begin
         count_q   <= '0;
         running_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         running_q <= running_d;
      end
   end

   // Combinational so the FSM sees time_up on the edge where count leaves 1.
   assign time_up = (count_q == WIDTH'(1)) && !hold && !load_timer;
   assign warn    = (count_q != '0) && (count_q <= WIDTH'(WARN_THRESH));
   assign count   = count_q;
   assign running = running_q;

   bin_to_bcd #(
      .IN_W (WIDTH)
   ) u_bin_to_bcd (
      .bin      (count_q),
      .hundreds (bcd_hundreds),
      .tens     (bcd_tens),
      .ones     (bcd_ones)
   );

endmodule
